// File: rtl/dw01_sub_seq.sv
// dw01_sub_seq: multi-cycle chunked subtractor, DIFF = A - B - BI, CHUNK bits per cycle, LSB first
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      high in IDLE, operands accepted on in_valid&in_ready
//   A, B       in   width  minuend, subtrahend
//   BI         in   1      borrow-in
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      consumer accepts result
//   DIFF       out  width  A - B - BI mod 2^width
//   BO         out  1      borrow-out, 1 when A < B + BI unsigned
//   busy       out  1      high in CALC or DONE
//   ovf        out  1      two's-complement overflow, present only with DW01_SUB_SEQ_OVF_EN defined
module dw01_sub_seq #(
  parameter int width = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             BI,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] DIFF,
  output logic             BO,
  output logic             busy
`ifdef DW01_SUB_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NCHUNK = width / CHUNK;
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [width-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic borrow_q, borrow_d, bo_q, bo_d;
  logic [31:0] base;
  logic [CHUNK:0] sub;
`ifdef DW01_SUB_SEQ_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign DIFF      = diff_q;
  assign BO        = bo_q;
  assign base      = 32'(cnt_q) * CHUNK;
  // The extra top bit of the chunk difference goes negative exactly when a borrow is needed.
  assign sub = {1'b0, a_q[base +: CHUNK]} - {1'b0, b_q[base +: CHUNK]} - {{CHUNK{1'b0}}, borrow_q};
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bo_d     = bo_q;
`ifdef DW01_SUB_SEQ_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        a_d      = A;
        b_d      = B;
        borrow_d = BI;
        cnt_d    = '0;
        state_d  = CALC;
      end
      CALC: begin
        diff_d[base +: CHUNK] = sub[CHUNK-1:0];
        borrow_d = sub[CHUNK];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          bo_d    = sub[CHUNK];
          cnt_d   = '0;
          state_d = DONE;
`ifdef DW01_SUB_SEQ_OVF_EN
          // The final chunk carries the result MSB.
          ovf_d   = (a_q[width-1] != b_q[width-1]) && (sub[CHUNK-1] != a_q[width-1]);
`endif
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bo_q     <= 1'b0;
`ifdef DW01_SUB_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bo_q     <= bo_d;
`ifdef DW01_SUB_SEQ_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end
endmodule
